// File: rtl/flash_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : flash_spi_responder
// Purpose  : SPI (mode 0) serial-flash responder. Answers READ (0x03) from a
//            byte-wide backing memory with one-byte prefetch, JEDEC ID (0x9F)
//            from a parameter, and silently ignores everything else.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock      in   system clock, all logic on rising edge
//   resetb     in   asynchronous active-low reset
//   csb        in   SPI chip select, active-low (asynchronous)
//   sck        in   SPI clock, mode 0, <= clock/8 (asynchronous)
//   mosi       in   SPI data in, MSB first
//   miso       out  SPI data out, MSB first, 0 when not driven
//   miso_oe    out  high while miso is actively driven
//   mem_rd     out  one-cycle read strobe to backing memory
//   mem_addr   out  [ADDR_WIDTH] read byte address, valid with mem_rd
//   mem_rdata  in   [8] read data, valid one clock after mem_rd
//   busy       out  high whenever the FSM is not idle
//   cmd_err    out  one-cycle pulse on an unsupported command byte
// ============================================================================
module flash_spi_responder #(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4018
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic                  csb,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic                  cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_ID     = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  localparam logic [7:0]            C_CMD_READ  = 8'h03;
  localparam logic [7:0]            C_CMD_JEDEC = 8'h9F;
  localparam logic [7:0]            C_CMD_RES   = 8'hAB;
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE  = ADDR_WIDTH'(1);

  state_t                r_state;
  logic                  r_csb_s1, r_csb_s2, r_armed;
  logic                  r_sck_s1, r_sck_s2, r_sck_prev;
  logic                  r_mosi_s1, r_mosi_s2;
  logic [7:0]            r_rx;
  logic [2:0]            r_bit;
  logic [1:0]            r_byte;
  logic                  r_done;
  logic [15:0]           r_addr;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_rd, r_rd_q;
  logic                  r_first_load, r_first;
  logic [7:0]            r_tx, r_pf_buf;
  logic                  r_miso, r_oe, r_busy, r_cmd_err;

  logic                  w_sck_rise, w_sck_fall;
  logic [7:0]            w_rx_next;
  logic [23:0]           w_addr_full;
  logic [7:0]            w_id_byte;
  logic [7:0]            w_load_byte;

  assign w_sck_rise  = r_sck_s2 & ~r_sck_prev;
  assign w_sck_fall  = ~r_sck_s2 & r_sck_prev;
  assign w_rx_next   = {r_rx[6:0], r_mosi_s2};
  assign w_addr_full = {r_addr, w_rx_next};

  always_comb begin
    w_id_byte = 8'h00;
    case (r_byte)
      2'd0:    w_id_byte = JEDEC_ID[23:16];
      2'd1:    w_id_byte = JEDEC_ID[15:8];
      2'd2:    w_id_byte = JEDEC_ID[7:0];
      default: w_id_byte = 8'h00;
    endcase
  end

  // Byte presented at a byte-boundary fall. The very first DATA byte was
  // loaded straight into r_tx; every later one comes from the prefetch buffer.
  assign w_load_byte = (r_state == S_ID) ? w_id_byte : (r_first ? r_tx : r_pf_buf);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state      <= S_IDLE;
      r_csb_s1     <= 1'b0;
      r_csb_s2     <= 1'b0;
      r_armed      <= 1'b0;
      r_sck_s1     <= 1'b0;
      r_sck_s2     <= 1'b0;
      r_sck_prev   <= 1'b0;
      r_mosi_s1    <= 1'b0;
      r_mosi_s2    <= 1'b0;
      r_rx         <= 8'h00;
      r_bit        <= 3'd0;
      r_byte       <= 2'd0;
      r_done       <= 1'b0;
      r_addr       <= 16'h0000;
      r_next_addr  <= '0;
      r_mem_addr   <= '0;
      r_mem_rd     <= 1'b0;
      r_rd_q       <= 1'b0;
      r_first_load <= 1'b0;
      r_first      <= 1'b0;
      r_tx         <= 8'h00;
      r_pf_buf     <= 8'h00;
      r_miso       <= 1'b0;
      r_oe         <= 1'b0;
      r_busy       <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_csb_s1   <= csb;
      r_csb_s2   <= r_csb_s1;
      r_sck_s1   <= sck;
      r_sck_s2   <= r_sck_s1;
      r_sck_prev <= r_sck_s2;
      r_mosi_s1  <= mosi;
      r_mosi_s2  <= r_mosi_s1;
      r_mem_rd   <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_rd_q     <= r_mem_rd;
      r_done     <= 1'b0;

      if (r_csb_s2) begin
        // Deselect: abort everything. Arming here means a select that is
        // already low when reset releases is never treated as a new frame.
        r_armed      <= 1'b1;
        r_state      <= S_IDLE;
        r_busy       <= 1'b0;
        r_oe         <= 1'b0;
        r_miso       <= 1'b0;
        r_bit        <= 3'd0;
        r_byte       <= 2'd0;
        r_rd_q       <= 1'b0;
        r_first_load <= 1'b0;
        r_first      <= 1'b0;
      end else begin
        if (r_rd_q) begin
          if (r_first_load) begin
            r_tx         <= mem_rdata;
            r_first_load <= 1'b0;
            r_mem_rd     <= 1'b1;
            r_mem_addr   <= r_next_addr;
            r_next_addr  <= r_next_addr + C_ADDR_ONE;
          end else begin
            r_pf_buf <= mem_rdata;
          end
        end

        if (w_sck_rise && (r_state != S_IDLE)) begin
          r_bit  <= r_bit + 3'd1;
          r_rx   <= w_rx_next;
          r_done <= (r_state == S_CMD) && (r_bit == 3'd7);
        end

        case (r_state)
          S_IDLE: begin
            if (r_armed) begin
              r_state <= S_CMD;
              r_busy  <= 1'b1;
            end
          end
          S_CMD: begin
            if (r_done) begin
              case (r_rx)
                C_CMD_READ:  r_state <= S_ADDR;
                C_CMD_JEDEC: begin
                  r_state <= S_ID;
                  r_oe    <= 1'b1;
                end
                C_CMD_RES:   r_state <= S_IGNORE;
                default: begin
                  r_state   <= S_IGNORE;
                  r_cmd_err <= 1'b1;
                end
              endcase
            end
          end
          S_ADDR: begin
            if (w_sck_rise && (r_bit == 3'd7)) begin
              if (r_byte == 2'd2) begin
                r_byte       <= 2'd0;
                r_mem_rd     <= 1'b1;
                r_mem_addr   <= w_addr_full[ADDR_WIDTH-1:0];
                r_next_addr  <= w_addr_full[ADDR_WIDTH-1:0] + C_ADDR_ONE;
                r_first_load <= 1'b1;
                r_first      <= 1'b1;
                r_state      <= S_DATA;
                r_oe         <= 1'b1;
              end else begin
                r_addr <= {r_addr[7:0], w_rx_next};
                r_byte <= r_byte + 2'd1;
              end
            end
          end
          S_DATA, S_ID: begin
            if (w_sck_fall) begin
              if (r_bit == 3'd0) begin
                r_miso <= w_load_byte[7];
                r_tx   <= {w_load_byte[6:0], 1'b0};
                if (r_state == S_ID) begin
                  if (r_byte != 2'd3) r_byte <= r_byte + 2'd1;
                end else if (r_first) begin
                  r_first <= 1'b0;
                end else begin
                  r_mem_rd    <= 1'b1;
                  r_mem_addr  <= r_next_addr;
                  r_next_addr <= r_next_addr + C_ADDR_ONE;
                end
              end else begin
                r_miso <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign miso     = r_miso;
  assign miso_oe  = r_oe;
  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign busy     = r_busy;
  assign cmd_err  = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_flash_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_spi_responder
// Purpose  : Self-checking bench for flash_spi_responder. Drives SPI frames
//            from a bit-banged master and compares against a byte-level
//            reference model of the flash (memory array + JEDEC table).
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_spi_responder;

  localparam int unsigned ADDR_WIDTH = 24;
  localparam logic [23:0] JEDEC_ID   = 24'hEF4018;

  logic                  clock = 1'b0;
  logic                  resetb = 1'b0;
  logic                  csb = 1'b1;
  logic                  sck = 1'b0;
  logic                  mosi = 1'b0;
  logic                  miso, miso_oe, mem_rd, busy, cmd_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_rdata = 8'h00;

  int n_vec = 0;
  int n_err = 0;
  int half  = 4;

  logic [7:0]  mem [int];
  logic [7:0]  rx_q[$];
  logic [23:0] addr_q[$];
  int unsigned rd_count, consec_count, miso_viol, oe_count, err_count;
  logic        prev_rd = 1'b0;

  flash_spi_responder #(.ADDR_WIDTH(ADDR_WIDTH), .JEDEC_ID(JEDEC_ID)) dut (
    .clock(clock), .resetb(resetb), .csb(csb), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clock = ~clock;

  // Reference flash contents: explicit entries, otherwise a fixed pattern.
  function automatic logic [7:0] mem_read(input logic [23:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // Backing memory: data one clock after the strobe.
  always @(posedge clock) if (mem_rd) mem_rdata <= mem_read(mem_addr);

  // Bus observer, sampled on the inactive edge.
  always @(negedge clock) begin
    if (mem_rd) begin
      rd_count++;
      addr_q.push_back(mem_addr);
      if (prev_rd) consec_count++;
    end
    prev_rd = mem_rd;
    if (!miso_oe && (miso !== 1'b0)) miso_viol++;
    if (miso_oe) oe_count++;
    if (cmd_err) err_count++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    rd_count = 0; consec_count = 0; miso_viol = 0; oe_count = 0; err_count = 0;
    addr_q.delete();
  endtask

  task automatic wait_half();
    repeat (half) @(posedge clock);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      wait_half();
      r = {r[6:0], miso};
      sck = 1'b1;
      wait_half();
      sck = 1'b0;
    end
  endtask

  task automatic csb_start();
    @(posedge clock); #1;
    csb = 1'b0;
    wait_half();
    wait_half();
  endtask

  task automatic csb_end(input int gap);
    wait_half();
    csb = 1'b1;
    repeat (gap) @(posedge clock);
    #1;
  endtask

  task automatic send_read(input logic [23:0] a, input int n, input int gap);
    logic [7:0] r;
    rx_q.delete();
    csb_start();
    spi_bits(8'h03, 8, r);
    spi_bits(a[23:16], 8, r);
    spi_bits(a[15:8], 8, r);
    spi_bits(a[7:0], 8, r);
    for (int i = 0; i < n; i++) begin
      spi_bits(8'($urandom), 8, r);
      rx_q.push_back(r);
    end
    csb_end(gap);
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_vec++; if (miso !== 1'b0)    begin n_err++; $display("FAIL reset miso: got %b expected 0", miso); end
    n_vec++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL reset miso_oe: got %b expected 0", miso_oe); end
    n_vec++; if (mem_rd !== 1'b0)  begin n_err++; $display("FAIL reset mem_rd: got %b expected 0", mem_rd); end
    n_vec++; if (mem_addr !== '0)  begin n_err++; $display("FAIL reset mem_addr: got %h expected 0", mem_addr); end
    n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_vec++; if (cmd_err !== 1'b0) begin n_err++; $display("FAIL reset cmd_err: got %b expected 0", cmd_err); end
    resetb = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset idle busy: got %b expected 0", busy); end
  endtask

  task automatic test_read_basic();
    clear_mon();
    half = 4;
    mem[32'h10] = 8'hA5;
    mem[32'h11] = 8'h3C;
    send_read(24'h000010, 2, 10);
    n_vec++; if (rx_q[0] !== 8'hA5) begin n_err++; $display("FAIL read_basic byte0: got %h expected a5", rx_q[0]); end
    n_vec++; if (rx_q[1] !== 8'h3C) begin n_err++; $display("FAIL read_basic byte1: got %h expected 3c", rx_q[1]); end
    n_vec++;
    if (addr_q.size() < 3) begin
      n_err++; $display("FAIL read_basic addr count: got %0d expected >=3", addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (addr_q[i] !== 24'h10 + 24'(i)) begin
          n_err++; $display("FAIL read_basic addr%0d: got %h expected %h", i, addr_q[i], 24'h10 + 24'(i));
        end
      end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL read_basic busy after: got %b expected 0", busy); end
    n_vec++; if (miso_viol != 0) begin n_err++; $display("FAIL read_basic miso idle: got %0d expected 0", miso_viol); end
  endtask

  task automatic test_jedec();
    logic [7:0] r;
    logic [7:0] exp_b [5];
    exp_b[0] = JEDEC_ID[23:16]; exp_b[1] = JEDEC_ID[15:8]; exp_b[2] = JEDEC_ID[7:0];
    exp_b[3] = 8'h00; exp_b[4] = 8'h00;
    clear_mon();
    half = 5;
    csb_start();
    spi_bits(8'h9F, 8, r);
    for (int i = 0; i < 5; i++) begin
      spi_bits(8'($urandom), 8, r);
      n_vec++;
      if (r !== exp_b[i]) begin n_err++; $display("FAIL jedec byte%0d: got %h expected %h", i, r, exp_b[i]); end
    end
    csb_end(10);
    n_vec++; if (rd_count != 0) begin n_err++; $display("FAIL jedec mem_rd count: got %0d expected 0", rd_count); end
    n_vec++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL jedec oe after: got %b expected 0", miso_oe); end
  endtask

  task automatic test_unsupported();
    logic [7:0] r;
    logic [7:0] c;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) c = 8'h55;
      else if (k == 1) c = 8'hAB;
      else begin
        do c = 8'($urandom); while (c inside {8'h03, 8'h9F, 8'hAB});
      end
      clear_mon();
      half = 4 + k;
      csb_start();
      spi_bits(c, 8, r);
      spi_bits(8'($urandom), 8, r);
      spi_bits(8'($urandom), 8, r);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL unsup %h busy held: got %b expected 1", c, busy); end
      csb_end(10);
      n_vec++;
      if (err_count != ((c == 8'hAB) ? 0 : 1)) begin
        n_err++; $display("FAIL unsup %h cmd_err pulses: got %0d expected %0d", c, err_count, (c == 8'hAB) ? 0 : 1);
      end
      n_vec++; if (oe_count != 0) begin n_err++; $display("FAIL unsup %h oe cycles: got %0d expected 0", c, oe_count); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL unsup %h busy after: got %b expected 0", c, busy); end
      n_vec++; if (rd_count != 0) begin n_err++; $display("FAIL unsup %h mem_rd count: got %0d expected 0", c, rd_count); end
    end
  endtask

  task automatic test_abort_wrap();
    logic [7:0] r;
    clear_mon();
    half = 4;
    csb_start();
    spi_bits(8'h03, 8, r);
    spi_bits(8'h12, 8, r);
    spi_bits(8'h34, 4, r);
    csb_end(10);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort busy: got %b expected 0", busy); end
    n_vec++; if (rd_count != 0) begin n_err++; $display("FAIL abort mem_rd count: got %0d expected 0", rd_count); end
    mem[32'hFFFFFF] = 8'($urandom);
    mem[32'h000000] = 8'($urandom);
    mem[32'h000001] = 8'($urandom);
    clear_mon();
    send_read(24'hFFFFFF, 2, 10);
    n_vec++; if (rx_q[0] !== mem_read(24'hFFFFFF)) begin n_err++; $display("FAIL wrap byte0: got %h expected %h", rx_q[0], mem_read(24'hFFFFFF)); end
    n_vec++; if (rx_q[1] !== mem_read(24'h000000)) begin n_err++; $display("FAIL wrap byte1: got %h expected %h", rx_q[1], mem_read(24'h000000)); end
    n_vec++;
    if (addr_q.size() < 2) begin
      n_err++; $display("FAIL wrap addr count: got %0d expected >=2", addr_q.size());
    end else begin
      n_vec++; if (addr_q[0] !== 24'hFFFFFF) begin n_err++; $display("FAIL wrap addr0: got %h expected ffffff", addr_q[0]); end
      n_vec++; if (addr_q[1] !== 24'h000000) begin n_err++; $display("FAIL wrap addr1: got %h expected 000000", addr_q[1]); end
    end
  endtask

  task automatic test_random_reads();
    logic [23:0] a, ea;
    int n;
    for (int k = 0; k < 6; k++) begin
      a    = 24'($urandom);
      if (k == 5) a = 24'hFFFFFD;
      n    = int'($urandom_range(1, 6));
      half = int'($urandom_range(4, 7));
      for (int i = 0; i < n + 3; i++) mem[int'(a + 24'(i))] = 8'($urandom);
      clear_mon();
      send_read(a, n, 10);
      for (int i = 0; i < n; i++) begin
        ea = a + 24'(i);
        n_vec++;
        if (rx_q[i] !== mem_read(ea)) begin n_err++; $display("FAIL rand read %h byte%0d: got %h expected %h", a, i, rx_q[i], mem_read(ea)); end
      end
      n_vec++;
      if (addr_q.size() < n + 1) begin n_err++; $display("FAIL rand read %h addr count: got %0d expected >=%0d", a, addr_q.size(), n + 1); end
      for (int i = 0; i < addr_q.size(); i++) begin
        n_vec++;
        if (addr_q[i] !== a + 24'(i)) begin n_err++; $display("FAIL rand read %h addr%0d: got %h expected %h", a, i, addr_q[i], a + 24'(i)); end
      end
      n_vec++; if (consec_count != 0) begin n_err++; $display("FAIL rand read %h mem_rd back-to-back: got %0d expected 0", a, consec_count); end
      n_vec++; if (miso_viol != 0) begin n_err++; $display("FAIL rand read %h miso idle: got %0d expected 0", a, miso_viol); end
    end
  endtask

  task automatic test_reset_mid_data();
    logic [7:0]  r;
    logic [23:0] a;
    a = 24'($urandom) | 24'h000100;
    half = 4;
    for (int i = 0; i < 4; i++) mem[int'(a + 24'(i))] = 8'($urandom);
    clear_mon();
    csb_start();
    spi_bits(8'h03, 8, r);
    spi_bits(a[23:16], 8, r);
    spi_bits(a[15:8], 8, r);
    spi_bits(a[7:0], 8, r);
    spi_bits(8'h00, 8, r);
    n_vec++; if (r !== mem_read(a)) begin n_err++; $display("FAIL rstmid byte0: got %h expected %h", r, mem_read(a)); end
    spi_bits(8'h00, 4, r);
    @(posedge clock); #2;
    resetb = 1'b0;
    #3;
    n_vec++; if (miso !== 1'b0)    begin n_err++; $display("FAIL rstmid miso: got %b expected 0", miso); end
    n_vec++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL rstmid miso_oe: got %b expected 0", miso_oe); end
    n_vec++; if (mem_rd !== 1'b0)  begin n_err++; $display("FAIL rstmid mem_rd: got %b expected 0", mem_rd); end
    n_vec++; if (mem_addr !== '0)  begin n_err++; $display("FAIL rstmid mem_addr: got %h expected 0", mem_addr); end
    n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL rstmid busy: got %b expected 0", busy); end
    n_vec++; if (cmd_err !== 1'b0) begin n_err++; $display("FAIL rstmid cmd_err: got %b expected 0", cmd_err); end
    repeat (3) @(posedge clock);
    #1;
    resetb = 1'b1;
    clear_mon();
    spi_bits(8'h00, 4, r);
    spi_bits(8'h03, 8, r);
    spi_bits(8'h9F, 8, r);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid stale csb busy: got %b expected 0", busy); end
    csb_end(10);
    n_vec++; if (oe_count != 0) begin n_err++; $display("FAIL rstmid stale csb oe cycles: got %0d expected 0", oe_count); end
    n_vec++; if (rd_count != 0) begin n_err++; $display("FAIL rstmid stale csb mem_rd: got %0d expected 0", rd_count); end
    n_vec++; if (err_count != 0) begin n_err++; $display("FAIL rstmid stale csb cmd_err: got %0d expected 0", err_count); end
    send_read(a, 3, 10);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (rx_q[i] !== mem_read(a + 24'(i))) begin n_err++; $display("FAIL rstmid reread byte%0d: got %h expected %h", i, rx_q[i], mem_read(a + 24'(i))); end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] a;
    int bad;
    half = 4;
    for (int k = 0; k < 2; k++) begin
      a = 24'($urandom);
      for (int i = 0; i < 67; i++) mem[int'(a + 24'(i))] = 8'($urandom);
      clear_mon();
      send_read(a, 64, 4);
      bad = 0;
      for (int i = 0; i < 64; i++) begin
        n_vec++;
        if (rx_q[i] !== mem_read(a + 24'(i))) begin
          n_err++; bad++;
          if (bad <= 4) $display("FAIL b2b %0d byte%0d: got %h expected %h", k, i, rx_q[i], mem_read(a + 24'(i)));
        end
      end
      n_vec++; if (consec_count != 0) begin n_err++; $display("FAIL b2b %0d mem_rd back-to-back: got %0d expected 0", k, consec_count); end
      n_vec++; if (addr_q.size() < 65) begin n_err++; $display("FAIL b2b %0d addr count: got %0d expected >=65", k, addr_q.size()); end
      bad = 0;
      for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== a + 24'(i)) bad++;
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL b2b %0d addr sequence: got %0d bad expected 0", k, bad); end
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_jedec();
    test_unsupported();
    test_abort_wrap();
    test_random_reads();
    test_reset_mid_data();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flash_spi_responder.md
FLASH_SPI_RESPONDER -- requirements
Module: flash_spi_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, byte-address width presented on mem_addr (range 1..24).
REQ-002 SHALL have parameter JEDEC_ID, default 24'hEF4018, the three ID bytes returned for command 0x9F, MSB byte first.
REQ-003 SHALL have port clock  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 SHALL have port resetb  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port csb  input  1  SPI chip select, active-low, asynchronous to clock.
REQ-006 SHALL have port sck  input  1  SPI clock, mode 0, asynchronous to clock, frequency at most clock/8.
REQ-007 SHALL have port mosi  input  1  SPI serial data in, MSB first.
REQ-008 SHALL have port miso  output  1  SPI serial data out, MSB first.
REQ-009 SHALL have port miso_oe  output  1  high while miso is actively driven.
REQ-010 SHALL have port mem_rd  output  1  one-cycle read strobe to the backing byte memory.
REQ-011 SHALL have port mem_addr  output  ADDR_WIDTH  read byte address, valid while mem_rd is high.
REQ-012 SHALL have port mem_rdata  input  8  read data, valid exactly one clock after mem_rd.
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-014 SHALL have port cmd_err  output  1  one-cycle pulse on an unsupported command byte.

Function
REQ-015 csb, sck and mosi SHALL each pass through a 2-flop synchronizer; sck edges SHALL be detected from the synchronized sck and its previous value.
REQ-016 On each detected sck rise, the synchronized mosi SHALL be shifted into an 8-bit receive register, LSB end; a 3-bit counter SHALL track bit position.
REQ-017 On each detected sck fall in DATA or ID state, miso SHALL advance to the next bit of the 8-bit transmit register, MSB first.
REQ-018 FSM states SHALL be IDLE, CMD, ADDR, DATA, ID, IGNORE.
REQ-019 IDLE -> CMD SHALL occur on the cycle synchronized csb is first seen low.
REQ-020 Synchronized csb high SHALL return the FSM to IDLE from any state within one clock. It SHALL clear the bit and byte counters, drop miso_oe, and cancel any further mem_rd.
REQ-021 In CMD, after the 8th rise: 0x03 -> ADDR; 0x9F -> ID; 0xAB -> IGNORE; any other value -> IGNORE plus a cmd_err pulse in the same cycle.
REQ-022 ADDR SHALL collect 24 bits MSB first; only the low ADDR_WIDTH bits SHALL be used.
REQ-023 On the 24th address rise, the block SHALL assert mem_rd with mem_addr set to the received address, then enter DATA.
REQ-024 The captured mem_rdata SHALL load the transmit register and drive bit 7 on the next sck fall.
REQ-025 After each transmit-register load, a prefetch mem_rd for address+1 SHALL issue.
REQ-026 Prefetch data SHALL be held in a buffer and moved to the transmit register on the sck fall following the byte's 8th rise.
REQ-027 Address increment SHALL wrap from 2^ADDR_WIDTH-1 to 0.
REQ-028 ID SHALL send the JEDEC_ID bytes in order, then 0x00 for any further bytes; no mem_rd SHALL issue.
REQ-029 IGNORE SHALL keep miso_oe low until csb deasserts.
REQ-030 miso_oe SHALL be high only in DATA and ID states; miso SHALL be 0 when miso_oe is low.
REQ-031 At most one mem_rd SHALL be outstanding; mem_rd SHALL never be asserted in two consecutive cycles.

Reset
REQ-032 While resetb is low: FSM=IDLE, miso=0, miso_oe=0, mem_rd=0, mem_addr=0, busy=0, cmd_err=0; counters, shift registers, prefetch buffer and synchronizers cleared.
REQ-033 Reset asserted mid-transaction SHALL abort it; after release the block SHALL wait for a fresh csb falling edge, ignoring a csb that is already low.

Verification
REQ-034 READ: mem[0x10]=0xA5, mem[0x11]=0x3C; send 03 00 00 10 and clock 16 bits -> miso yields A5 3C; mem_addr sequence 0x10, 0x11, 0x12.
REQ-035 JEDEC: send 9F and clock 32 bits -> miso yields EF 40 18 00; mem_rd never asserted.
REQ-036 Unsupported command: send 0x55 -> exactly one cmd_err pulse; miso_oe stays 0; busy stays 1 until csb high.
REQ-037 Abort and wrap: raise csb after 12 address bits -> IDLE, no mem_rd. Then READ at 0xFFFFFF -> mem_addr 0xFFFFFF then 0x000000.
REQ-038 Reset mid-DATA: pulse resetb low during byte 2 -> all outputs at reset values. After release with csb held low: no response. After csb high and a new READ: correct data.
REQ-039 Max rate: sck = clock/8 with back-to-back 64-byte READ -> every byte correct and no mem_rd overlap.
